// File: rtl/gate_test_pkg.sv
// ============================================================================
// Module   : gate_test_pkg
// Purpose  : State encodings, reference truth tables and the vector compare
//            helper for the truth-table sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Two-input reference tables, bit i = expected Y for input vector i.
  localparam logic [3:0] TRUTH_AND2  = 4'b1000;
  localparam logic [3:0] TRUTH_OR2   = 4'b1110;
  localparam logic [3:0] TRUTH_XOR2  = 4'b0110;
  localparam logic [3:0] TRUTH_NAND2 = 4'b0111;

  // Case inequality so an undriven or X gate output is reported as a failure.
  function automatic logic vec_mismatch(input logic y, input logic expected);
    return (y !== expected);
  endfunction

endpackage

`default_nettype wire

// File: rtl/truth_table_sequencer_settle_timer.sv
// ============================================================================
// Module   : settle_timer
// Purpose  : Loadable down-counter; EXPIRE is high once SETTLE cycles have
//            elapsed since LOAD.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic LOAD,
  output logic EXPIRE
);

  localparam int              CW       = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0]   LOAD_VAL = CW'(SETTLE - 1);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (LOAD) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign EXPIRE = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/truth_table_sequencer.sv
// ============================================================================
// Module   : truth_table_sequencer
// Purpose  : Walks every input vector of a gate under test, samples Y after a
//            settle time and scores it against TRUTH. Optional per-vector log
//            enabled by defining TRUTH_TABLE_LOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sequencer
  import gate_test_pkg::*;
#(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 2,
  parameter logic [2**N_IN-1:0]  TRUTH  = 4'b1000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            Y_IN,
  output logic [N_IN-1:0] A_OUT,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [N_IN:0]   ERR_CNT,
  output logic [N_IN-1:0] FIRST_ERR
);

  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(2**N_IN - 1);

  state_e          state_d,     state_q;
  logic [N_IN-1:0] idx_d,       idx_q;
  logic [N_IN-1:0] a_out_d,     a_out_q;
  logic            busy_d,      busy_q;
  logic            done_d,      done_q;
  logic            pass_d,      pass_q;
  logic [N_IN:0]   err_cnt_d,   err_cnt_q;
  logic [N_IN-1:0] first_err_d, first_err_q;

  logic timer_load;
  logic timer_expire;
  logic mismatch;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .CLK    (CLK),
    .RST    (RST),
    .LOAD   (timer_load),
    .EXPIRE (timer_expire)
  );

  assign mismatch = vec_mismatch(Y_IN, TRUTH[idx_q]);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_out_d     = a_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    timer_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d     = ST_SETTLE;
          idx_d       = '0;
          a_out_d     = '0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_cnt_d   = '0;
          first_err_d = '0;
          timer_load  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_expire) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_cnt_d = err_cnt_q + 1'b1;
          if (err_cnt_q == '0) begin
            first_err_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d    = ST_SETTLE;
          idx_d      = idx_q + 1'b1;
          a_out_d    = idx_q + 1'b1;
          timer_load = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_out_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_out_q     <= a_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

`ifdef TRUTH_TABLE_LOG_EN
  always_ff @(posedge CLK) begin
    if (!RST && state_q == ST_SAMPLE) begin
      $display("A=%b Y=%b EXP=%b%s", a_out_q, Y_IN, TRUTH[idx_q],
               mismatch ? " MISMATCH" : "");
    end
    if (!RST && state_q == ST_FINISH) begin
      $display("ERRORS=%0d", err_cnt_q);
    end
  end
`else
`endif

  assign A_OUT     = a_out_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign ERR_CNT   = err_cnt_q;
  assign FIRST_ERR = first_err_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
// ============================================================================
// Module   : tb_truth_table_sequencer
// Purpose  : Scoreboard bench for truth_table_sequencer with AND, OR-table and
//            3-input AND configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_sequencer;

  typedef struct {
    int done_cyc;
    int err;
    int first;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default AND table, AND gate.
  logic       start_a = 1'b0, force_x_a = 1'b0, y_a;
  logic [1:0] a_aout, a_first;
  logic [2:0] a_err;
  logic       a_busy, a_done, a_pass;
  // Instance O: OR table, AND gate attached.
  logic       start_o = 1'b0, y_o;
  logic [1:0] o_aout, o_first;
  logic [2:0] o_err;
  logic       o_busy, o_done, o_pass;
  // Instance T: 3-input AND, SETTLE=1.
  logic       start_t = 1'b0, y_t;
  logic [2:0] t_aout, t_first;
  logic [3:0] t_err;
  logic       t_busy, t_done, t_pass;

  assign y_a = (force_x_a && a_aout == 2'b11) ? 1'bx : &a_aout;
  assign y_o = &o_aout;
  assign y_t = &t_aout;

  truth_table_sequencer dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .Y_IN(y_a), .A_OUT(a_aout), .BUSY(a_busy),
    .DONE(a_done), .PASS(a_pass), .ERR_CNT(a_err), .FIRST_ERR(a_first)
  );

  truth_table_sequencer #(.N_IN(2), .SETTLE(2), .TRUTH(4'b1110)) dut_o (
    .CLK(clk), .RST(rst), .START(start_o), .Y_IN(y_o), .A_OUT(o_aout), .BUSY(o_busy),
    .DONE(o_done), .PASS(o_pass), .ERR_CNT(o_err), .FIRST_ERR(o_first)
  );

  truth_table_sequencer #(.N_IN(3), .SETTLE(1), .TRUTH(8'b10000000)) dut_t (
    .CLK(clk), .RST(rst), .START(start_t), .Y_IN(y_t), .A_OUT(t_aout), .BUSY(t_busy),
    .DONE(t_done), .PASS(t_pass), .ERR_CNT(t_err), .FIRST_ERR(t_first)
  );

  exp_t q_a[$];
  exp_t q_o[$];
  exp_t q_t[$];

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic unexpected_done(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got DONE at cycle %0d, required no DONE", name, cyc);
  endtask

  // Monitors: pop the expected result whenever a DONE pulse is seen.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_done === 1'b1) begin
      if (q_a.size() == 0) unexpected_done("a_done_unexpected");
      else begin
        e = q_a.pop_front();
        chk("a_done_cycle", cyc, e.done_cyc);
        chk("a_err_cnt", int'(a_err), e.err);
        chk("a_first_err", int'(a_first), e.first);
        chk("a_pass", int'(a_pass), e.pass);
        chk("a_busy_at_done", int'(a_busy), 0);
      end
    end
  end

  always @(negedge clk) begin : mon_o
    exp_t e;
    if (o_done === 1'b1) begin
      if (q_o.size() == 0) unexpected_done("o_done_unexpected");
      else begin
        e = q_o.pop_front();
        chk("o_done_cycle", cyc, e.done_cyc);
        chk("o_err_cnt", int'(o_err), e.err);
        chk("o_first_err", int'(o_first), e.first);
        chk("o_pass", int'(o_pass), e.pass);
      end
    end
  end

  always @(negedge clk) begin : mon_t
    exp_t e;
    if (t_done === 1'b1) begin
      if (q_t.size() == 0) unexpected_done("t_done_unexpected");
      else begin
        e = q_t.pop_front();
        chk("t_done_cycle", cyc, e.done_cyc);
        chk("t_err_cnt", int'(t_err), e.err);
        chk("t_first_err", int'(t_first), e.first);
        chk("t_pass", int'(t_pass), e.pass);
      end
    end
  end

  // Called at a negedge; returns at the following negedge, where cyc == k.
  task automatic start_pulse(input int which, output int k);
    k = cyc + 1;
    case (which)
      0:       start_a = 1'b1;
      1:       start_o = 1'b1;
      default: start_t = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0;
    start_o = 1'b0;
    start_t = 1'b0;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_aout"},  int'(a_aout),  0);
    chk({tag, "_busy"},  int'(a_busy),  0);
    chk({tag, "_done"},  int'(a_done),  0);
    chk({tag, "_pass"},  int'(a_pass),  0);
    chk({tag, "_err"},   int'(a_err),   0);
    chk({tag, "_first"}, int'(a_first), 0);
  endtask

  initial begin
    int k;
    exp_t e;

    // Reset state
    repeat (3) @(negedge clk);
    chk_a_zero("rst_a");
    chk("rst_o_aout", int'(o_aout), 0);
    chk("rst_t_err", int'(t_err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // AND table, AND gate: vectors 00,01,10,11 each held 3 cycles
    start_pulse(0, k);
    e = '{k + 12, 0, 0, 1}; q_a.push_back(e);
    chk("t1_busy_after_start", int'(a_busy), 1);
    for (int j = 0; j <= 12; j++) begin
      chk("t1_a_out_seq", int'(a_aout), (j < 12) ? j / 3 : 3);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("t1_pass_hold", int'(a_pass), 1);
    chk("t1_aout_hold", int'(a_aout), 3);
    chk("t1_busy_idle", int'(a_busy), 0);

    // OR table with AND gate, START held high across two runs
    k = cyc + 1;
    start_o = 1'b1;
    e = '{k + 12, 2, 1, 0}; q_o.push_back(e);
    e = '{k + 26, 2, 1, 0}; q_o.push_back(e);
    repeat (15) @(negedge clk);
    chk("o_restart_busy", int'(o_busy), 1);
    chk("o_restart_err_cleared", int'(o_err), 0);
    start_o = 1'b0;
    repeat (16) @(negedge clk);
    chk("o_pass_hold", int'(o_pass), 0);

    // X on Y_IN for vector 3
    force_x_a = 1'b1;
    start_pulse(0, k);
    e = '{k + 12, 1, 3, 0}; q_a.push_back(e);
    repeat (14) @(negedge clk);
    force_x_a = 1'b0;
    chk("x_err_hold", int'(a_err), 1);

    // START in SETTLE of vector 2 and in FINISH is ignored; run starts fresh
    start_pulse(0, k);
    e = '{k + 12, 0, 0, 1}; q_a.push_back(e);
    chk("ign_err_cleared", int'(a_err), 0);
    chk("ign_pass_cleared", int'(a_pass), 0);
    for (int j = 0; j <= 20; j++) begin
      start_a = (j == 6 || j == 12) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start_a = 1'b0;
    chk("ign_busy_idle", int'(a_busy), 0);

    // Asynchronous reset mid-run while idx == 2
    start_pulse(0, k);
    repeat (7) @(negedge clk);
    chk("rst_mid_aout_before", int'(a_aout), 2);
    #2 rst = 1'b1;
    #1 chk_a_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_busy_after", int'(a_busy), 0);
    chk("rst_mid_aout_after", int'(a_aout), 0);

    // 3-input AND, SETTLE=1: 8 vectors, DONE 16 cycles after START
    start_pulse(2, k);
    e = '{k + 16, 0, 0, 1}; q_t.push_back(e);
    repeat (20) @(negedge clk);
    chk("t_aout_hold", int'(t_aout), 7);

    chk("q_a_empty", q_a.size(), 0);
    chk("q_o_empty", q_o.size(), 0);
    chk("q_t_empty", q_t.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
